// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg
//   Shared constants for the hex display scheduler:
//     - active-low seven-segment patterns for 0..F (bit0 = a ... bit6 = g)
//     - SEG_BLANK, the all-segments-off pattern
//     - scheduler state encoding (IDLE / SCAN / COMMIT)
//     - digit geometry (nibble width, number of board digits)
package hex_disp_pkg;

  localparam int DIGIT_W        = 4;
  localparam int NUM_DIGITS_MAX = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Two-bit state encoding; the fourth code is unused and recovers to IDLE.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder
//   Purely combinational hex-to-seven-segment decoder. The scheduler
//   instantiates exactly one of these and time-shares it over all digits.
//   Ports:
//     nibble   in  4  hex digit to decode
//     segments out 7  active-low segments, bit0 = a ... bit6 = g
module hex_seg_decoder
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (nibble)
      4'h0: segments = SEG_0;
      4'h1: segments = SEG_1;
      4'h2: segments = SEG_2;
      4'h3: segments = SEG_3;
      4'h4: segments = SEG_4;
      4'h5: segments = SEG_5;
      4'h6: segments = SEG_6;
      4'h7: segments = SEG_7;
      4'h8: segments = SEG_8;
      4'h9: segments = SEG_9;
      4'hA: segments = SEG_A;
      4'hB: segments = SEG_B;
      4'hC: segments = SEG_C;
      4'hD: segments = SEG_D;
      4'hE: segments = SEG_E;
      4'hF: segments = SEG_F;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler
//   Accepts a 24-bit value over a valid/ready handshake, walks its six
//   nibbles (most significant first) through one shared segment decoder
//   into staging registers, then commits all six digits to the display
//   registers on a single edge so the display never shows a mix of old and
//   new digits. Leading zeros can optionally be blanked; digit 0 is always
//   shown. Accept-to-display latency is 7 clocks, minimum period 8 clocks.
//   Ports:
//     clock     in  1   system clock
//     resetn    in  1   synchronous active-low reset
//     value     in  24  hex value, nibble k drives HEXk
//     blank_en  in  1   1 = blank leading zero digits
//     load      in  1   request to display value (valid)
//     ready     out 1   high while idle, a load is accepted this cycle
//     done      out 1   one-cycle pulse after the new value is committed
//     HEX0..5   out 7   active-low segments, bit0 = a ... bit6 = g
module hex_display_scheduler
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_MAX
)
(
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] value,
  input  logic                          blank_en,
  input  logic                          load,
  output logic                          ready,
  output logic                          done,
  output logic [6:0]                    HEX0,
  output logic [6:0]                    HEX1,
  output logic [6:0]                    HEX2,
  output logic [6:0]                    HEX3,
  output logic [6:0]                    HEX4,
  output logic [6:0]                    HEX5
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [1:0]                    state;
  logic [2:0]                    idx;
  logic                          nz_seen;
  logic [NUM_DIGITS*DIGIT_W-1:0] shadow_value;
  logic                          shadow_blank;
  logic [6:0]                    staging [NUM_DIGITS];

  logic [3:0]                    cur_nibble;
  logic [6:0]                    cur_segments;
  logic                          blank_digit;

  // ready comes straight off the state register so there is no
  // combinational path from load back to ready.
  assign ready = (state == ST_IDLE);

  // {idx, 2'b00} is idx * DIGIT_W for the 4-bit nibble width.
  assign cur_nibble = shadow_value[{idx, 2'b00} +: DIGIT_W];

  hex_seg_decoder u_decoder (
    .nibble   (cur_nibble),
    .segments (cur_segments)
  );

  // nz_seen still reflects only the digits above idx, so this blanks a
  // zero only while everything to its left was zero as well.
  assign blank_digit = shadow_blank & ~nz_seen & (cur_nibble == 4'h0) & (idx != 3'd0);

  // Control: handshake capture, scan index walk and the done pulse.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      idx          <= '0;
      nz_seen      <= 1'b0;
      shadow_value <= '0;
      shadow_blank <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            shadow_value <= value;
            shadow_blank <= blank_en;
            idx          <= LAST_IDX;
            nz_seen      <= 1'b0;
            state        <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cur_nibble != 4'h0) begin
            nz_seen <= 1'b1;
          end
          if (idx == 3'd0) begin
            state <= ST_COMMIT;
          end else begin
            idx <= idx - 3'd1;
          end
        end
        ST_COMMIT: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: staging fills one digit per scan edge; the display registers
  // only change on the commit edge, all six together.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        staging[i] <= SEG_BLANK;
      end
      HEX0 <= SEG_BLANK;
      HEX1 <= SEG_BLANK;
      HEX2 <= SEG_BLANK;
      HEX3 <= SEG_BLANK;
      HEX4 <= SEG_BLANK;
      HEX5 <= SEG_BLANK;
    end else begin
      if (state == ST_SCAN) begin
        staging[idx] <= blank_digit ? SEG_BLANK : cur_segments;
      end
      if (state == ST_COMMIT) begin
        HEX0 <= staging[0];
        HEX1 <= staging[1];
        HEX2 <= staging[2];
        HEX3 <= staging[3];
        HEX4 <= staging[4];
        HEX5 <= staging[5];
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb_hex_display_scheduler
//   Directed bench for hex_display_scheduler. A cycle-counting model of the
//   handshake and display (expected digits computed from the value with a
//   lookup table and a leading-zero walk) is checked against every output
//   on every falling edge; a set of hand-computed literals pins the model.
module tb_hex_display_scheduler;

  logic        clock;
  logic        resetn;
  logic [23:0] value;
  logic        blank_en;
  logic        load;
  logic        ready;
  logic        done;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int compared   = 0;
  int mismatched = 0;

  hex_display_scheduler #(.NUM_DIGITS(6)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .value    (value),
    .blank_en (blank_en),
    .load     (load),
    .ready    (ready),
    .done     (done),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference segment table, active-low.
  logic [6:0] seg_ref [16];
  initial begin
    seg_ref[0]  = 7'h40; seg_ref[1]  = 7'h79; seg_ref[2]  = 7'h24; seg_ref[3]  = 7'h30;
    seg_ref[4]  = 7'h19; seg_ref[5]  = 7'h12; seg_ref[6]  = 7'h02; seg_ref[7]  = 7'h78;
    seg_ref[8]  = 7'h00; seg_ref[9]  = 7'h10; seg_ref[10] = 7'h08; seg_ref[11] = 7'h03;
    seg_ref[12] = 7'h46; seg_ref[13] = 7'h21; seg_ref[14] = 7'h06; seg_ref[15] = 7'h0E;
  end

  task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: m_cnt counts edges left until the commit; 0 means idle.
  int         m_cnt = 0;
  bit         m_on  = 0;
  logic       m_done = 1'b0;
  logic [6:0] m_hex  [6];
  logic [6:0] m_pend [6];

  always @(posedge clock) begin
    m_on = 1;
    if (!resetn) begin
      m_cnt  = 0;
      m_done = 1'b0;
      for (int k = 0; k < 6; k++) m_hex[k] = 7'h7F;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0) begin
        if (load) begin
          bit seen;
          seen = 0;
          for (int k = 5; k >= 0; k--) begin
            logic [3:0] nib;
            nib = value[k*4 +: 4];
            if (blank_en && !seen && nib == 4'h0 && k != 0) m_pend[k] = 7'h7F;
            else m_pend[k] = seg_ref[nib];
            if (nib != 4'h0) seen = 1;
          end
          m_cnt = 7;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          for (int k = 0; k < 6; k++) m_hex[k] = m_pend[k];
          m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_on) begin
      checkOutput("ready", {6'd0, ready}, {6'd0, (m_cnt == 0)});
      checkOutput("done",  {6'd0, done},  {6'd0, m_done});
      checkOutput("HEX0", HEX0, m_hex[0]);
      checkOutput("HEX1", HEX1, m_hex[1]);
      checkOutput("HEX2", HEX2, m_hex[2]);
      checkOutput("HEX3", HEX3, m_hex[3]);
      checkOutput("HEX4", HEX4, m_hex[4]);
      checkOutput("HEX5", HEX5, m_hex[5]);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic rstn, input logic ld, input logic [23:0] val, input logic blk);
    resetn   = rstn;
    load     = ld;
    value    = val;
    blank_en = blk;
  endtask

  logic [23:0] t6_vals [3];
  logic        t6_blks [3];

  initial begin
    t6_vals[0] = 24'h0C0DE0; t6_blks[0] = 1'b1;
    t6_vals[1] = 24'h5A5A5A; t6_blks[1] = 1'b0;
    t6_vals[2] = 24'h00F001; t6_blks[2] = 1'b1;

    // Reset with load asserted: nothing may be captured.
    applyStimulus(1'b0, 1'b1, 24'hABCDEF, 1'b0);
    tick();
    checkOutput("rst_HEX0", HEX0, 7'h7F);
    checkOutput("rst_HEX5", HEX5, 7'h7F);
    checkOutput("rst_ready", {6'd0, ready}, 7'd1);
    checkOutput("rst_done", {6'd0, done}, 7'd0);
    applyStimulus(1'b1, 1'b0, 24'hABCDEF, 1'b0);
    repeat (3) tick();
    checkOutput("rst_nocap_done", {6'd0, done}, 7'd0);

    // Plain decode, no blanking.
    applyStimulus(1'b1, 1'b1, 24'h12AB3F, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 24'h000000, 1'b0);
    repeat (6) tick();
    checkOutput("t2_E6_HEX5", HEX5, 7'h7F);
    tick();
    checkOutput("t2_HEX5", HEX5, 7'h79);
    checkOutput("t2_HEX4", HEX4, 7'h24);
    checkOutput("t2_HEX3", HEX3, 7'h08);
    checkOutput("t2_HEX2", HEX2, 7'h03);
    checkOutput("t2_HEX1", HEX1, 7'h30);
    checkOutput("t2_HEX0", HEX0, 7'h0E);
    checkOutput("t2_done", {6'd0, done}, 7'd1);
    tick();
    checkOutput("t2_done_off", {6'd0, done}, 7'd0);

    // Leading-zero blanking, interior zero kept.
    applyStimulus(1'b1, 1'b1, 24'h000405, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 24'h000000, 1'b0);
    repeat (7) tick();
    checkOutput("t3_HEX5", HEX5, 7'h7F);
    checkOutput("t3_HEX4", HEX4, 7'h7F);
    checkOutput("t3_HEX3", HEX3, 7'h7F);
    checkOutput("t3_HEX2", HEX2, 7'h19);
    checkOutput("t3_HEX1", HEX1, 7'h40);
    checkOutput("t3_HEX0", HEX0, 7'h12);
    applyStimulus(1'b1, 1'b1, 24'h000000, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 24'h000000, 1'b0);
    repeat (7) tick();
    checkOutput("t3z_HEX0", HEX0, 7'h40);
    checkOutput("t3z_HEX1", HEX1, 7'h7F);
    checkOutput("t3z_HEX5", HEX5, 7'h7F);

    // Load held through a scan is ignored until ready returns.
    applyStimulus(1'b1, 1'b1, 24'h111111, 1'b0);
    tick();
    checkOutput("t4_busy", {6'd0, ready}, 7'd0);
    repeat (2) tick();
    applyStimulus(1'b1, 1'b1, 24'h222222, 1'b0);
    repeat (5) tick();
    checkOutput("t4_HEX0", HEX0, 7'h79);
    checkOutput("t4_HEX5", HEX5, 7'h79);
    checkOutput("t4_ready", {6'd0, ready}, 7'd1);
    tick();
    checkOutput("t4_E8_busy", {6'd0, ready}, 7'd0);
    applyStimulus(1'b1, 1'b0, 24'h000000, 1'b0);
    repeat (7) tick();
    checkOutput("t4b_HEX3", HEX3, 7'h24);

    // Mid-scan reset aborts without a done pulse.
    applyStimulus(1'b1, 1'b1, 24'hFFFFFF, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 24'h000000, 1'b0);
    repeat (2) tick();
    applyStimulus(1'b0, 1'b0, 24'h000000, 1'b0);
    tick();
    checkOutput("t5_HEX2", HEX2, 7'h7F);
    checkOutput("t5_ready", {6'd0, ready}, 7'd1);
    applyStimulus(1'b1, 1'b0, 24'h000000, 1'b0);
    repeat (10) tick();
    checkOutput("t5_HEX0", HEX0, 7'h7F);

    // Back-to-back accepts every 8 clocks with load held high.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, t6_vals[i], t6_blks[i]);
      tick();
      applyStimulus(1'b1, 1'b1, 24'hDEAD00 ^ 24'(i), ~t6_blks[i]);
      repeat (7) tick();
      checkOutput("t6_done", {6'd0, done}, 7'd1);
    end
    checkOutput("t6_HEX4", HEX4, 7'h7F);
    checkOutput("t6_HEX3", HEX3, 7'h0E);
    checkOutput("t6_HEX0", HEX0, 7'h79);
    applyStimulus(1'b1, 1'b0, 24'h000000, 1'b0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
Time-shares one combinational hex-to-seven-segment decoder across the six board digits HEX5..HEX0.
- Accepts a 24-bit value through a valid/ready handshake.
- Walks the six nibbles through the shared decoder, one per clock, into staging registers.
- Commits all six digits to the display registers in a single cycle, so the display never tears.
- Optionally blanks leading zeros.

Parameters:
NUM_DIGITS, 6, number of digits scanned (fixed at 6 for the board; the package constants assume 6).

Ports:
clock  in  1  system clock; the only clock.
resetn  in  1  reset, synchronous, active-low.
value  in  24  hex value; nibble k drives HEXk.
blank_en  in  1  1 = blank leading zero digits.
load  in  1  request to display value (valid).
ready  out  1  high when a load is accepted this cycle.
done  out  1  one-cycle pulse when the new value is committed.
HEX0..HEX5  out  7 each  active-low segments; bit0 = segment a ... bit6 = segment g.

Behaviour:
- Reset (resetn=0 at a rising edge):
  - state IDLE, done=0.
  - All staging registers and HEX0..HEX5 = 7'h7F (blank).
  - Scan index cleared.
  - Applies mid-operation: an in-flight scan is aborted and no done pulse is issued.
- ready = (state==IDLE); decoded from the state register only, with no combinational path from load.
- Accept rule: load & ready at edge E0.
  - value and blank_en are captured into shadow registers; later changes to value/blank_en have no effect.
  - idx = NUM_DIGITS-1; nz_seen = 0; state goes to SCAN.
  - load while ready=0 is ignored; nothing is captured.
- SCAN, edges E1..E6: one digit per edge, most significant first (idx 5 down to 0).
  - The shared decoder converts shadow nibble idx.
  - Staging[idx] = 7'h7F if blank_en & ~nz_seen & nibble==0 & idx!=0; otherwise staging[idx] = decoder output.
  - nz_seen is set once any nibble is nonzero.
  - Digit 0 is never blanked.
  - At idx==0, state goes to COMMIT.
- COMMIT, edge E7:
  - HEX0..HEX5 <= staging, all simultaneously.
  - done <= 1 for exactly one cycle.
  - state goes to IDLE.
- Latency: 7 clocks from accepting edge to display update. HEX outputs hold their previous values until E7.
- Throughput: ready returns high after E7, so the next accept is at E8 at the earliest; the minimum period is 8 clocks.
- Segment table (active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- All outputs are registered.
- States: IDLE, SCAN, COMMIT. Unused encodings go to IDLE.

Decomposition:
- Package hex_disp_pkg:
  - the 16-entry segment pattern constants
  - SEG_BLANK = 7'h7F
  - the state encoding (IDLE/SCAN/COMMIT)
  - DIGIT_W = 4 and NUM_DIGITS_MAX = 6
- Sub-module hex_seg_decoder: 4-bit in, 7-bit active-low out, purely combinational, instantiated exactly once (this is the shared resource).

Test Plan:
1. Reset: resetn=0 for 1 edge with load=1 -> HEX0..HEX5=7F, ready=1, done=0, no capture.
2. load 24'h12AB3F, blank_en=0, at E0 -> HEX all 7F through E6.
   - At E7: HEX5=79, HEX4=24, HEX3=08, HEX2=03, HEX1=30, HEX0=0E; done high one cycle.
3. blank_en=1, value 24'h000405 -> HEX5=HEX4=HEX3=7F, HEX2=19, HEX1=40 (interior zero shown), HEX0=12.
   - Then value 24'h000000 with blank_en=1 -> HEX0=40, HEX1..HEX5=7F.
4. Accept 24'h111111, then at E3 drive value 24'h222222 with load=1 -> ready=0 during E1..E7, so the second load is ignored.
   - At E7 all HEX=79.
   - Because load is still held, the second value is accepted at E8.
5. Accept 24'hFFFFFF, then resetn=0 at E3 -> after E3 state IDLE, HEX all 7F, no done pulse afterwards, ready=1.
6. load held high continuously with alternating values -> accepts at E0, E8, E16.
   - done pulses one cycle after E7, E15, ...
   - Each commit matches the value present at its accepting edge.
